// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/ifun/stat encodings, CC bit positions and the branch/cmov condition helper.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;
  localparam logic [3:0] A_MUL = 4'h4;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic lt;
    logic zf;
    lt = flags[CC_SF] ^ flags[CC_OF];
    zf = flags[CC_ZF];
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt | zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return ~zf;
      4'd5:    return ~lt;
      4'd6:    return ~lt & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// rtl/y86_alu.sv - combinational OPq ALU (add/sub/and/xor of b op a) with ZF/SF/OF.
module y86_alu
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        fun,
  output logic [DATA_W-1:0] res,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  logic sa, sb, sr;

  always_comb begin
    res = '0;
    case (fun)
      A_ADD[1:0]: res = b + a;
      A_SUB[1:0]: res = b - a;
      A_AND[1:0]: res = b & a;
      A_XOR[1:0]: res = b ^ a;
      default:    res = '0;
    endcase
  end

  assign sa = a[DATA_W-1];
  assign sb = b[DATA_W-1];
  assign sr = res[DATA_W-1];
  assign zf = (res == '0);
  assign sf = sr;

  // Subtraction is b - a, so overflow is judged against b's sign.
  always_comb begin
    of = 1'b0;
    if (fun == A_ADD[1:0])      of = (sa == sb) && (sr != sa);
    else if (fun == A_SUB[1:0]) of = (sb != sa) && (sr != sb);
  end

endmodule

// File: rtl/y86_execute_stage.sv
// rtl/y86_execute_stage.sv - Y86-64 execute stage, CC register and E->M pipeline register; EXEC_MUL_EN adds multi-cycle mulq.
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int STACK_STEP = 8,
  parameter int MUL_LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_Cnd,
  output logic [2:0]        cc,
  output logic              e_busy,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam int MUL_K = DATA_W / MUL_LAT;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [DATA_W-1:0] CHUNK_MASK = {DATA_W{1'b1}} >> (DATA_W - MUL_K);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt, step;
  logic [DATA_W-1:0] mul_acc, mul_sum, mul_chunk;
  logic              is_opq, is_mul, op_invalid, mul_last, cc_we;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zf, alu_sf, alu_of;
  logic [2:0]        cc_next;

  assign is_opq     = (E_icode == I_OPQ);
  assign is_mul     = MUL_EN && is_opq && (E_ifun == A_MUL) && (E_stat == S_AOK);
  assign op_invalid = is_opq && (E_ifun > A_XOR) && !(MUL_EN && (E_ifun == A_MUL));

  y86_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (E_valA),
    .b   (E_valB),
    .fun (E_ifun[1:0]),
    .res (alu_res),
    .zf  (alu_zf),
    .sf  (alu_sf),
    .of  (alu_of)
  );

  // One MUL_K-bit slice of valB per cycle; the IDLE cycle handles slice 0.
  always_comb begin
    step      = (state == ST_MUL) ? cnt : '0;
    mul_chunk = (E_valB >> (MUL_K * int'(step))) & CHUNK_MASK;
    mul_sum   = ((state == ST_MUL) ? mul_acc : '0) + ((E_valA * mul_chunk) << (MUL_K * int'(step)));
    mul_last  = (step == CNT_W'(MUL_LAT - 1));
  end

  assign e_busy = is_mul && !mul_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mul_acc <= '0;
    end else if (!is_mul || M_bubble || mul_last) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state   <= ST_MUL;
      cnt     <= step + CNT_W'(1);
      mul_acc <= mul_sum;
    end
  end

  always_comb begin
    e_valE = '0;
    case (E_icode)
      I_OPQ: begin
        if (!op_invalid) e_valE = (E_ifun == A_MUL) ? (is_mul ? mul_sum : '0) : alu_res;
      end
      I_IRMOVQ:          e_valE = E_valC;
      I_RMMOVQ, I_MRMOVQ: e_valE = E_valB + E_valC;
      I_CMOV:            e_valE = E_valA;
      I_CALL, I_PUSHQ:   e_valE = E_valB - STEP;
      I_RET, I_POPQ:     e_valE = E_valB + STEP;
      default:           e_valE = '0;
    endcase
  end

  assign e_Cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond_eval(E_ifun, cc) : 1'b0;
  assign e_dstE = ((E_icode == I_CMOV) && !e_Cnd) ? RNONE : E_dstE;

  // Older instructions faulting downstream must not see their CC side effects overtaken.
  assign cc_we = is_opq && (E_stat == S_AOK) && (m_stat == S_AOK) && (W_stat == S_AOK) &&
                 !op_invalid && !e_busy && !(is_mul && M_bubble);
  assign cc_next = is_mul ? {1'b0, e_valE[DATA_W-1], (e_valE == '0)} : {alu_of, alu_sf, alu_zf};

  always_ff @(posedge clk) begin
    if (rst)        cc <= 3'b001;
    else if (cc_we) cc <= cc_next;
  end

  always_ff @(posedge clk) begin
    if (rst || M_bubble || (!M_stall && e_busy)) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= (op_invalid && (E_stat == S_AOK)) ? S_INS : E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule
